// File: rtl/grf_wb_arbiter_pkg.sv
// rtl/grf_wb_arbiter_pkg.sv - shared GRF widths and the hard-wired zero register
package grf_wb_arbiter_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

endpackage

// File: rtl/grf_wb_arbiter_fifo.sv
// rtl/grf_wb_arbiter_fifo.sv - in-order aux write buffer with per-entry kill and address match
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   push, push_addr/data/pc    enqueue one entry (caller guarantees not full)
//   pop                        retire the head slot (caller guarantees not empty)
//   kill_en, kill_addr         invalidate every valid entry with this address
//   match_a1, match_a2         lookup addresses
//   match1, match2             per-slot valid && address-equal vectors
//   head_valid, head_*         head slot occupied and still valid, and its contents
//   any_valid                  at least one valid entry held
//   count                      occupied slots, 0..DEPTH
module wb_fifo
    import grf_wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [ADDR_W-1:0]          push_addr,
    input  logic [DATA_W-1:0]          push_data,
    input  logic [DATA_W-1:0]          push_pc,
    input  logic                       pop,
    input  logic                       kill_en,
    input  logic [ADDR_W-1:0]          kill_addr,
    input  logic [ADDR_W-1:0]          match_a1,
    input  logic [ADDR_W-1:0]          match_a2,
    output logic [DEPTH-1:0]           match1,
    output logic [DEPTH-1:0]           match2,
    output logic                       head_valid,
    output logic [ADDR_W-1:0]          head_addr,
    output logic [DATA_W-1:0]          head_data,
    output logic [DATA_W-1:0]          head_pc,
    output logic                       any_valid,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);

    logic [DEPTH-1:0]  valid;
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] pc_q   [DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;

    // Free slots always hold valid=0, so |valid covers occupied slots only.
    assign any_valid  = |valid;
    assign head_valid = (count != '0) && valid[rd_ptr];
    assign head_addr  = addr_q[rd_ptr];
    assign head_data  = data_q[rd_ptr];
    assign head_pc    = pc_q[rd_ptr];

    always_comb begin
        match1 = '0;
        match2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match1[i] = valid[i] && (addr_q[i] == match_a1);
            match2[i] = valid[i] && (addr_q[i] == match_a2);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (kill_en && valid[i] && (addr_q[i] == kill_addr)) begin
                    valid[i] <= 1'b0;
                end
            end
            if (pop) begin
                valid[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + 1'b1;
            end
            // Written after the kill loop: a same-edge push is younger than
            // the killing write and must survive.
            if (push) begin
                valid[wr_ptr]  <= 1'b1;
                addr_q[wr_ptr] <= push_addr;
                data_q[wr_ptr] <= push_data;
                pc_q[wr_ptr]   <= push_pc;
                wr_ptr         <= wr_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/grf_wb_arbiter.sv
// rtl/grf_wb_arbiter.sv - GRF write-port arbiter between W stage and aux unit
//
// Ports:
//   Clk, Reset                      clock, synchronous active-high reset
//   w0_we/addr/data/pc              W-stage write, never back-pressured
//   r1_valid/ready/addr/data/pc     aux write handshake
//   q_a1, q_a2                      decode read addresses
//   pend1, pend2                    read address has an in-flight aux write
//   stall_req                       ask hazard unit for a W-stage bubble
//   grf_we/a3/wd/pc                 GRF write port
module grf_wb_arbiter
    import grf_wb_arbiter_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              w0_we,
    input  logic [ADDR_W-1:0] w0_addr,
    input  logic [DATA_W-1:0] w0_data,
    input  logic [DATA_W-1:0] w0_pc,
    input  logic              r1_valid,
    output logic              r1_ready,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_data,
    input  logic [DATA_W-1:0] r1_pc,
    input  logic [ADDR_W-1:0] q_a1,
    input  logic [ADDR_W-1:0] q_a2,
    output logic              pend1,
    output logic              pend2,
    output logic              stall_req,
    output logic              grf_we,
    output logic [ADDR_W-1:0] grf_a3,
    output logic [DATA_W-1:0] grf_wd,
    output logic [DATA_W-1:0] grf_pc
);

    localparam int CW  = $clog2(DEPTH) + 1;
    localparam int SCW = $clog2(STARVE_MAX + 1);

    logic [DEPTH-1:0]  match1;
    logic [DEPTH-1:0]  match2;
    logic              head_valid;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic [DATA_W-1:0] head_pc;
    logic              any_valid;
    logic [CW-1:0]     count;
    logic [SCW-1:0]    sc;

    logic w0_active;
    logic push;
    logic pop;

    assign w0_active = w0_we && (w0_addr != REG_ZERO);
    assign r1_ready  = (count < CW'(DEPTH));
    // $0 aux writes are acknowledged but never occupy a slot.
    assign push      = !Reset && r1_valid && r1_ready && (r1_addr != REG_ZERO);
    // Any occupied head leaves on an idle W cycle; killed ones simply write nothing.
    assign pop       = !Reset && !w0_active && (count != '0);

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (Clk),
        .reset      (Reset),
        .push       (push),
        .push_addr  (r1_addr),
        .push_data  (r1_data),
        .push_pc    (r1_pc),
        .pop        (pop),
        .kill_en    (w0_active),
        .kill_addr  (w0_addr),
        .match_a1   (q_a1),
        .match_a2   (q_a2),
        .match1     (match1),
        .match2     (match2),
        .head_valid (head_valid),
        .head_addr  (head_addr),
        .head_data  (head_data),
        .head_pc    (head_pc),
        .any_valid  (any_valid),
        .count      (count)
    );

    // The popping entry stays visible here: the GRF only takes it at the edge.
    assign pend1 = (q_a1 != REG_ZERO) && (|match1);
    assign pend2 = (q_a2 != REG_ZERO) && (|match2);

    // During Reset the FIFO is not allowed to drive the port; W stays live.
    always_comb begin
        grf_we = 1'b0;
        grf_a3 = '0;
        grf_wd = '0;
        grf_pc = '0;
        if (Reset || w0_active) begin
            grf_we = w0_we;
            grf_a3 = w0_addr;
            grf_wd = w0_data;
            grf_pc = w0_pc;
        end else if (head_valid) begin
            grf_we = 1'b1;
            grf_a3 = head_addr;
            grf_wd = head_data;
            grf_pc = head_pc;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            sc <= '0;
        end else if (pop || !any_valid) begin
            sc <= '0;
        end else if (head_valid && w0_active && (sc != SCW'(STARVE_MAX))) begin
            sc <= sc + 1'b1;
        end
    end

    assign stall_req = (sc == SCW'(STARVE_MAX));

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// tb/tb_grf_wb_arbiter.sv - self-checking bench for grf_wb_arbiter
module tb_grf_wb_arbiter;

    localparam int DEPTH      = 2;
    localparam int STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        w0_we;
    logic [4:0]  w0_addr;
    logic [31:0] w0_data;
    logic [31:0] w0_pc;
    logic        r1_valid;
    logic        r1_ready;
    logic [4:0]  r1_addr;
    logic [31:0] r1_data;
    logic [31:0] r1_pc;
    logic [4:0]  q_a1;
    logic [4:0]  q_a2;
    logic        pend1;
    logic        pend2;
    logic        stall_req;
    logic        grf_we;
    logic [4:0]  grf_a3;
    logic [31:0] grf_wd;
    logic [31:0] grf_pc;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        bit          valid;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] pc;
    } entry_t;

    entry_t mq[$];
    int     msc = 0;

    always #5 clk = ~clk;

    grf_wb_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .Clk       (clk),
        .Reset     (reset),
        .w0_we     (w0_we),
        .w0_addr   (w0_addr),
        .w0_data   (w0_data),
        .w0_pc     (w0_pc),
        .r1_valid  (r1_valid),
        .r1_ready  (r1_ready),
        .r1_addr   (r1_addr),
        .r1_data   (r1_data),
        .r1_pc     (r1_pc),
        .q_a1      (q_a1),
        .q_a2      (q_a2),
        .pend1     (pend1),
        .pend2     (pend2),
        .stall_req (stall_req),
        .grf_we    (grf_we),
        .grf_a3    (grf_a3),
        .grf_wd    (grf_wd),
        .grf_pc    (grf_pc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_idle();
        w0_we = 0; w0_addr = 0; w0_data = 0; w0_pc = 0;
        r1_valid = 0; r1_addr = 0; r1_data = 0; r1_pc = 0;
        q_a1 = 0; q_a2 = 0;
    endtask

    task automatic set_w0(input logic [4:0] a, input logic [31:0] d);
        w0_we = 1; w0_addr = a; w0_data = d; w0_pc = 32'h0040_0000 + {22'd0, a, 2'b00};
    endtask

    task automatic set_r1(input logic [4:0] a, input logic [31:0] d);
        r1_valid = 1; r1_addr = a; r1_data = d; r1_pc = 32'h0050_0000 + {22'd0, a, 2'b00};
    endtask

    function automatic bit pend_of(input logic [4:0] a);
        if (a == 0) return 0;
        foreach (mq[i]) if (mq[i].valid && mq[i].addr == a) return 1;
        return 0;
    endfunction

    // Called at a negedge with inputs set; checks outputs, then applies the edge to the model.
    task automatic tick();
        bit          act;
        bit          exp_ready;
        bit          any_v;
        bit          hv;
        bit          pop;
        logic        e_we;
        logic [4:0]  e_a3;
        logic [31:0] e_wd;
        logic [31:0] e_pc;
        act       = w0_we && (w0_addr != 0);
        exp_ready = (mq.size() < DEPTH);
        hv        = (mq.size() > 0) && mq[0].valid;
        any_v     = 0;
        foreach (mq[i]) if (mq[i].valid) any_v = 1;
        if (reset || act) begin
            e_we = w0_we; e_a3 = w0_addr; e_wd = w0_data; e_pc = w0_pc;
        end else if (hv) begin
            e_we = 1; e_a3 = mq[0].addr; e_wd = mq[0].data; e_pc = mq[0].pc;
        end else begin
            e_we = 0; e_a3 = 0; e_wd = 0; e_pc = 0;
        end
        #1;
        chk("r1_ready", {31'd0, r1_ready}, {31'd0, exp_ready});
        chk("grf_we", {31'd0, grf_we}, {31'd0, e_we});
        chk("grf_a3", {27'd0, grf_a3}, {27'd0, e_a3});
        chk("grf_wd", grf_wd, e_wd);
        chk("grf_pc", grf_pc, e_pc);
        chk("pend1", {31'd0, pend1}, {31'd0, pend_of(q_a1)});
        chk("pend2", {31'd0, pend2}, {31'd0, pend_of(q_a2)});
        chk("stall_req", {31'd0, stall_req}, {31'd0, (msc == STARVE_MAX)});
        @(posedge clk);
        if (reset) begin
            mq.delete();
            msc = 0;
        end else begin
            pop = !act && (mq.size() > 0);
            if (pop || !any_v) msc = 0;
            else if (hv && act && msc < STARVE_MAX) msc++;
            if (act) foreach (mq[i]) if (mq[i].valid && mq[i].addr == w0_addr) mq[i].valid = 0;
            if (pop) void'(mq.pop_front());
            if (r1_valid && exp_ready && r1_addr != 0)
                mq.push_back('{1'b1, r1_addr, r1_data, r1_pc});
        end
        @(negedge clk);
    endtask

    initial begin
        set_idle();
        reset = 1;
        @(negedge clk);
        tick();
        tick();
        reset = 0;

        // reset then idle
        #1;
        chk("t1_ready", {31'd0, r1_ready}, 32'd1);
        chk("t1_we", {31'd0, grf_we}, 32'd0);
        tick();

        // W-stage pass-through
        set_w0(5'd5, 32'h1234);
        #1;
        chk("t2_a3", {27'd0, grf_a3}, 32'd5);
        chk("t2_wd", grf_wd, 32'h1234);
        tick();
        set_idle();

        // single aux write drains next cycle, pending until that edge
        set_r1(5'd8, 32'hAA);
        tick();
        set_idle();
        q_a1 = 5'd8;
        #1;
        chk("t3_pend1", {31'd0, pend1}, 32'd1);
        chk("t3_wd", grf_wd, 32'hAA);
        tick();
        #1;
        chk("t3_pend1_after", {31'd0, pend1}, 32'd0);
        tick();

        // fill under W pressure, starve, then drain in order
        set_w0(5'd20, 32'h20); set_r1(5'd9, 32'h99);
        tick();
        set_r1(5'd10, 32'h1010);
        tick();
        r1_valid = 0;
        #1;
        chk("t4_full", {31'd0, r1_ready}, 32'd0);
        for (int i = 0; i < 4; i++) tick();
        #1;
        chk("t4_stall", {31'd0, stall_req}, 32'd1);
        set_idle();
        #1;
        chk("t4_first", {27'd0, grf_a3}, 32'd9);
        tick();
        #1;
        chk("t4_second", {27'd0, grf_a3}, 32'd10);
        tick();
        tick();

        // ordering kill
        set_w0(5'd20, 32'h20); set_r1(5'd3, 32'h1);
        tick();
        r1_valid = 0;
        set_w0(5'd3, 32'h2);
        #1;
        chk("t5_w0", grf_wd, 32'h2);
        tick();
        set_idle();
        #1;
        chk("t5_silent", {31'd0, grf_we}, 32'd0);
        tick();
        tick();

        // reset with a full FIFO
        set_w0(5'd20, 32'h20); set_r1(5'd11, 32'hB);
        tick();
        set_r1(5'd12, 32'hC);
        tick();
        set_idle();
        reset = 1;
        #1;
        chk("t6_no_drain", {31'd0, grf_we}, 32'd0);
        tick();
        reset = 0;
        #1;
        chk("t6_ready", {31'd0, r1_ready}, 32'd1);
        chk("t6_we", {31'd0, grf_we}, 32'd0);
        tick();

        // randomized traffic
        for (int c = 0; c < 400; c++) begin
            reset    = ($urandom_range(0, 39) == 0);
            w0_we    = ($urandom_range(0, 2) != 0);
            w0_addr  = 5'($urandom_range(0, 6));
            w0_data  = $urandom;
            w0_pc    = $urandom;
            r1_valid = ($urandom_range(0, 1) != 0);
            r1_addr  = 5'($urandom_range(0, 6));
            r1_data  = $urandom;
            r1_pc    = $urandom;
            q_a1     = 5'($urandom_range(0, 6));
            q_a2     = 5'($urandom_range(0, 6));
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
